// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 data mux and
// forwarding the selected word downstream under a valid/ready handshake.
module rr_mux_arbiter #(
  parameter int W    = 8,
  parameter int HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] D,
  input  logic           ready,
  output logic [W-1:0]   y,
  output logic           valid,
  output logic           s1,
  output logic           s0,
  output logic [3:0]     gnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;
  logic [1:0] sel;

  logic [1:0] g;
  logic       xfer;
  logic       last;
  logic       rel;
  logic [2:0] pick_idle;
  logic [2:0] pick_rel;

  // Returns {found, index} of the first requester scanning p, p+1, p+2, p+3.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign s1 = sel[1];
  assign s0 = sel[0];

  always_comb begin
    g         = sel;
    xfer      = valid & ready;
    last      = xfer && (({1'b0, cnt} + 5'd1) == 5'(HOLD));
    rel       = !req[g] || last;
    pick_idle = rr_pick(req, ptr);
    // The granted index sits last in this scan, so it is only picked again
    // when nobody else is requesting.
    pick_rel  = rr_pick(req, g + 2'd1);
  end

  always_comb begin
    y = '0;
    if (valid) y = D[int'(sel)*W +: W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      valid <= 1'b0;
      sel   <= 2'b00;
      ptr   <= 2'b00;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[2]) begin
            gnt   <= 4'b0001 << pick_idle[1:0];
            sel   <= pick_idle[1:0];
            valid <= 1'b1;
            cnt   <= 4'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (rel) begin
            ptr <= g + 2'd1;
            if (pick_rel[2]) begin
              gnt <= 4'b0001 << pick_rel[1:0];
              sel <= pick_rel[1:0];
              cnt <= 4'd0;
            end else begin
              gnt   <= 4'b0000;
              valid <= 1'b0;
              state <= IDLE;
            end
          end else if (xfer) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: one instance with HOLD=4, one with HOLD=1
// sharing all inputs; each scenario checks the instance it targets.
module tb_rr_mux_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] D;
  logic           ready;

  logic [W-1:0] ya, yb;
  logic         va, vb, s1a, s0a, s1b, s0b;
  logic [3:0]   ga, gb;

  int n_chk  = 0;
  int n_fail = 0;

  rr_mux_arbiter #(.W(W), .HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .D(D), .ready(ready),
    .y(ya), .valid(va), .s1(s1a), .s0(s0a), .gnt(ga)
  );

  rr_mux_arbiter #(.W(W), .HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .D(D), .ready(ready),
    .y(yb), .valid(vb), .s1(s1b), .s0(s0b), .gnt(gb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] g, input logic v,
                         input logic [1:0] s, input logic [7:0] yy);
    check({tag, ".gnt"},   32'(ga), 32'(g));
    check({tag, ".valid"}, 32'(va), 32'(v));
    check({tag, ".sel"},   32'({s1a, s0a}), 32'(s));
    check({tag, ".y"},     32'(ya), 32'(yy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r, input logic rd);
    req   = r;
    ready = rd;
    rst   = 1'b1;
    #2;
    rst   = 1'b0;
  endtask

  logic [3:0] rot_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rot_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] rot_y [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

  initial begin
    D     = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b1111;
    ready = 1'b1;
    rst   = 1'b1;
    #1;
    // Reset state, then first grant one edge after release
    check_a("rst", 4'b0000, 1'b0, 2'd0, 8'h00);
    check("rst_b.gnt", 32'(gb), 32'h0);
    #2 rst = 1'b0;
    tick();
    check_a("first", 4'b0001, 1'b1, 2'd0, 8'h11);

    // Hold limit with a lone requester, then a competitor after the regrant
    do_reset(4'b0001, 1'b1);
    tick();
    check_a("hold.e0", 4'b0001, 1'b1, 2'd0, 8'h11);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_a($sformatf("hold.e%0d", i), 4'b0001, 1'b1, 2'd0, 8'h11);
    end
    req = 4'b0011;
    for (int i = 5; i <= 7; i++) begin
      tick();
      check_a($sformatf("hold.e%0d", i), 4'b0001, 1'b1, 2'd0, 8'h11);
    end
    tick();
    check_a("hold.rot", 4'b0010, 1'b1, 2'd1, 8'h22);

    // Rotation on the HOLD=1 instance
    do_reset(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rot%0d.gnt", i), 32'(gb), 32'(rot_g[i]));
      check($sformatf("rot%0d.sel", i), 32'({s1b, s0b}), 32'(rot_s[i]));
      check($sformatf("rot%0d.y", i), 32'(yb), 32'(rot_y[i]));
    end

    // Stall: grant holds through ready=0, then exactly HOLD transfers
    do_reset(4'b0100, 1'b0);
    tick();
    check_a("stall.grant", 4'b0100, 1'b1, 2'd2, 8'h33);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_a($sformatf("stall%0d", i), 4'b0100, 1'b1, 2'd2, 8'h33);
    end
    ready = 1'b1;
    req   = 4'b0101;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_a($sformatf("drain%0d", i), 4'b0100, 1'b1, 2'd2, 8'h33);
    end
    tick();
    check_a("drain.rot", 4'b0001, 1'b1, 2'd0, 8'h11);

    // Early drop with a competitor: back-to-back grant to requester 3
    do_reset(4'b0010, 1'b1);
    tick();
    check_a("drop.grant", 4'b0010, 1'b1, 2'd1, 8'h22);
    tick();
    check_a("drop.xfer", 4'b0010, 1'b1, 2'd1, 8'h22);
    req = 4'b1000;
    tick();
    check_a("drop.next", 4'b1000, 1'b1, 2'd3, 8'h44);

    // Early drop with no competitor: idle, select holds, pointer advanced to 2
    do_reset(4'b0010, 1'b1);
    tick();
    tick();
    req = 4'b0000;
    tick();
    check_a("idle", 4'b0000, 1'b0, 2'd1, 8'h00);
    check("idle.s1", 32'(s1a), 32'h0);
    check("idle.s0", 32'(s0a), 32'h1);
    tick();
    check_a("idle.hold", 4'b0000, 1'b0, 2'd1, 8'h00);
    req = 4'b0101;
    tick();
    check_a("idle.ptr", 4'b0100, 1'b1, 2'd2, 8'h33);

    // Asynchronous reset between edges while busy
    do_reset(4'b0100, 1'b0);
    tick();
    check_a("arst.busy", 4'b0100, 1'b1, 2'd2, 8'h33);
    #2 rst = 1'b1;
    #1;
    check_a("arst.clear", 4'b0000, 1'b0, 2'd0, 8'h00);
    #1 rst = 1'b0;
    req = 4'b1111;
    tick();
    check_a("arst.restart", 4'b0001, 1'b1, 2'd0, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 4:1 data multiplexer. Four requesters each present a W-bit word. The block grants one requester at a time, drives the mux select lines s1/s0 and a one-hot grant, and forwards the selected word to a single downstream consumer under a valid/ready handshake. A hold limit bounds how many transfers one requester may make before priority rotates.

Parameters:
W, 8, data width per requester and of output y
HOLD, 4, maximum accepted transfers per grant before forced rotation (legal range 1..15)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req  in  4  request per requester; req[i] belongs to requester i
D  in  4*W  packed data; D[i*W +: W] is requester i's word
ready  in  1  downstream accepts y this cycle when valid=1
y  out  W  selected data; D for index {s1,s0} when valid=1, else 0
valid  out  1  y carries a granted word
s1  out  1  mux select MSB (registered)
s0  out  1  mux select LSB (registered)
gnt  out  4  one-hot grant; all zero when idle

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, valid=0, {s1,s0}=2'b00, y=0, ptr=0, cnt=0.
- State: IDLE/BUSY, 2-bit priority pointer ptr, transfer counter cnt (4 bits).
- y is combinational from D and the registered {s1,s0}, gated by valid. s1, s0, gnt and valid are registers.
- Round-robin pick from a pointer p: the first i in the order p, p+1, p+2, p+3 (mod 4) with req[i]=1.
- IDLE: at the clock edge where req!=0, pick from ptr. Then:
  - set gnt to one-hot(i) and {s1,s0} to i;
  - set valid=1 and cnt=0;
  - go to BUSY.
  - Grant latency is 1 cycle from the edge that samples the request.
- IDLE with req=0: all outputs hold. {s1,s0} keeps the last granted index and gnt=0.
- BUSY, transfer: xfer = valid & ready. On xfer, cnt increments.
- BUSY, release condition at an edge, where g is the granted index:
  - release if req[g]=0, or
  - release if xfer occurs and cnt+1 == HOLD.
- On release:
  - ptr becomes g+1 mod 4.
  - If any requester other than g is requesting, grant the round-robin pick from g+1 in the same edge. This is back-to-back with no idle cycle; cnt=0.
  - Otherwise, if req[g]=1 (HOLD expiry with no competitor), regrant g with cnt=0.
  - Otherwise, go to IDLE with gnt=0 and valid=0.
- ready=0 stalls: cnt holds and the grant holds indefinitely while req[g]=1. There is no timeout.
- If req[g] drops in the same cycle as an xfer, the transfer counts and release occurs at that edge.
- If req[g] drops while ready=0, release occurs and the pending word is discarded. Requesters must hold req until their data is accepted.
- D changes during BUSY pass straight through to y. The block never latches data.
- Simultaneous requests from IDLE: the pointer decides. With ptr=0, req=4'b1010 grants requester 1.
- Wrap-around: ptr=3 scans 3,0,1,2.
- rst asserted mid-transfer: all outputs clear immediately, without waiting for clk.
- Invariants: gnt is one-hot or zero; gnt!=0 iff valid=1; when valid=1, gnt equals one-hot({s1,s0}).

Test Plan:
1. Reset state: assert rst with req=4'b1111 → immediately gnt=0, valid=0, s1=s0=0, y=0. Release rst, then at the first edge → gnt=0001 and y=D[0].
2. Hold limit: HOLD=4, ready=1, req=0001 constant → gnt=0001 for 4 cycles, then requester 0 is regranted with cnt reset. valid never drops and ptr=1.
3. Rotation: req=1111, ready=1, HOLD=1 → gnt sequence 0001, 0010, 0100, 1000, 0001. s1/s0 sequence 00, 01, 10, 11, 00. Each word appears on y.
4. Stall: granted requester 2, ready=0 for 10 cycles with req=0100 → gnt=0100 for all 10 cycles and y=D[2]. After ready=1, exactly HOLD transfers occur.
5. Early drop: requester 1 granted and req goes from 0010 to 1000 after one xfer → the next edge grants 1000 with {s1,s0}=11 and ptr=2. Dropping all requests instead → IDLE with gnt=0, valid=0, {s1,s0} holding 01.
6. Async reset mid-BUSY: rst pulse between clock edges while gnt=0100 → outputs clear before the next edge. After rst is released, arbitration restarts from ptr=0.
